// File: rtl/mean_compens_mc.sv
// Multi-channel DC-offset (mean) compensator with leaky-integrator mean and saturating subtract.
// Latency: 1 cycle from data_in/in_valid to data_out/out_valid (statistics 1 cycle later).
// Backpressure: none; every in_valid cycle is accepted, in_valid=0 holds state and drops out_valid.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   tau, tau_load         time-constant shift; the load pulse also restarts the accumulators and warm-up
//   in_valid, data_in     CHANNELS signed WIDTH-bit samples, channel 0 in the LSBs
//   data_out, out_valid   mean-compensated saturated samples, valid once warm-up completes
//   mag_thr               magnitude threshold for the occupancy statistics
//   sig_pct, mag_pct      per-channel 7-bit percentages of sig=1 / mag=1 over the last window
//   stat_stb              one-cycle pulse when sig_pct/mag_pct update
// Optional feature: define MEAN_COMPENS_STAT_EN to build the sign/magnitude occupancy statistics;
// without it sig_pct, mag_pct and stat_stb are constant 0 and mag_thr is ignored.
module mean_compens_mc #(
    parameter int CHANNELS       = 4,
    parameter int WIDTH          = 14,
    parameter int TAU_MAX        = 15,
    parameter int STAT_CNTR_SIZE = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  tau,
    input  logic                        tau_load,
    input  logic                        in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   data_in,
    output logic [CHANNELS*WIDTH-1:0]   data_out,
    output logic                        out_valid,
    input  logic [WIDTH-2:0]            mag_thr,
    output logic [CHANNELS*7-1:0]       sig_pct,
    output logic [CHANNELS*7-1:0]       mag_pct,
    output logic                        stat_stb
);

    localparam int ACC_W  = WIDTH + TAU_MAX + 1;
    localparam int TAU_W  = $clog2(TAU_MAX + 1);
    // Warm-up target is 2**(tau+2); the counter must hold the largest target itself.
    localparam int WARM_W = TAU_MAX + 3;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [WIDTH-1:0] smp_t;
    typedef logic signed [WIDTH:0]   dif_t;

    localparam smp_t SMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam smp_t SMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [TAU_W-1:0] clamp_tau(input logic [3:0] t);
        int ti;
        ti = int'(t);
        if (ti < 1) begin
            ti = 1;
        end else if (ti > TAU_MAX) begin
            ti = TAU_MAX;
        end
        return TAU_W'(ti);
    endfunction

    logic [TAU_W-1:0]  tau_q;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d, warm_tgt;
    logic              warm_d;
    logic              out_valid_q;
    acc_t              acc_q  [CHANNELS];
    acc_t              acc_d  [CHANNELS];
    smp_t              dout_q [CHANNELS];
    smp_t              dout_d [CHANNELS];
    dif_t              mean_c [CHANNELS];
    dif_t              diff_c [CHANNELS];

    always_comb begin
        warm_tgt   = WARM_W'(1) << (int'(tau_q) + 2);
        // Saturating count: once the target is reached the output stays qualified.
        warm_cnt_d = (warm_cnt_q == warm_tgt) ? warm_cnt_q : warm_cnt_q + WARM_W'(1);
        warm_d     = (warm_cnt_d == warm_tgt);
        for (int c = 0; c < CHANNELS; c++) begin
            // The leaky integrator keeps acc within (sample range) * 2**tau, so the
            // floor mean always fits WIDTH+1 bits and the difference cannot wrap.
            mean_c[c] = dif_t'(acc_q[c] >>> tau_q);
            diff_c[c] = dif_t'($signed(data_in[c*WIDTH +: WIDTH])) - mean_c[c];
            if (diff_c[c][WIDTH] != diff_c[c][WIDTH-1]) begin
                dout_d[c] = diff_c[c][WIDTH] ? SMP_MIN : SMP_MAX;
            end else begin
                dout_d[c] = diff_c[c][WIDTH-1:0];
            end
            acc_d[c] = acc_q[c] + acc_t'(diff_c[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tau_q       <= TAU_W'(4);
            warm_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]  <= '0;
                dout_q[c] <= '0;
            end
        end else if (tau_load) begin
            // The sample arriving with the load pulse is discarded; data_out keeps its value.
            tau_q       <= clamp_tau(tau);
            warm_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
            end
        end else if (in_valid) begin
            warm_cnt_q  <= warm_cnt_d;
            out_valid_q <= warm_d;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]  <= acc_d[c];
                dout_q[c] <= dout_d[c];
            end
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    always_comb begin
        data_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            data_out[c*WIDTH +: WIDTH] = dout_q[c];
        end
    end
    assign out_valid = out_valid_q;

`ifdef MEAN_COMPENS_STAT_EN
    // Statistics observe the registered output, so they trail data_out by one cycle.
    logic [STAT_CNTR_SIZE-1:0] win_q;
    logic [STAT_CNTR_SIZE:0]   sig_cnt_q [CHANNELS];
    logic [STAT_CNTR_SIZE:0]   mag_cnt_q [CHANNELS];
    logic [STAT_CNTR_SIZE:0]   sig_sum   [CHANNELS];
    logic [STAT_CNTR_SIZE:0]   mag_sum   [CHANNELS];
    logic [6:0]                sig_pct_q [CHANNELS];
    logic [6:0]                mag_pct_q [CHANNELS];
    logic [6:0]                sig_pct_d [CHANNELS];
    logic [6:0]                mag_pct_d [CHANNELS];
    logic [WIDTH-1:0]          abs_c     [CHANNELS];
    logic                      stb_q;
    logic                      win_end;

    always_comb begin
        win_end = (win_q == '1);
        for (int c = 0; c < CHANNELS; c++) begin
            // Unsigned WIDTH bits hold |-2**(WIDTH-1)| exactly.
            abs_c[c]     = dout_q[c][WIDTH-1] ? WIDTH'(-dout_q[c]) : WIDTH'(dout_q[c]);
            // Sums include the current sample so the window's last sample is counted.
            sig_sum[c]   = sig_cnt_q[c] + (STAT_CNTR_SIZE+1)'(~dout_q[c][WIDTH-1]);
            mag_sum[c]   = mag_cnt_q[c] + (STAT_CNTR_SIZE+1)'(abs_c[c] >= {1'b0, mag_thr});
            sig_pct_d[c] = 7'((int'(sig_sum[c]) * 100) >> STAT_CNTR_SIZE);
            mag_pct_d[c] = 7'((int'(mag_sum[c]) * 100) >> STAT_CNTR_SIZE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_q <= '0;
            stb_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                sig_cnt_q[c] <= '0;
                mag_cnt_q[c] <= '0;
                sig_pct_q[c] <= '0;
                mag_pct_q[c] <= '0;
            end
        end else begin
            stb_q <= 1'b0;
            if (tau_load) begin
                win_q <= '0;
                for (int c = 0; c < CHANNELS; c++) begin
                    sig_cnt_q[c] <= '0;
                    mag_cnt_q[c] <= '0;
                end
            end else if (out_valid_q) begin
                win_q <= win_q + STAT_CNTR_SIZE'(1);
                if (win_end) begin
                    stb_q <= 1'b1;
                    for (int c = 0; c < CHANNELS; c++) begin
                        sig_pct_q[c] <= sig_pct_d[c];
                        mag_pct_q[c] <= mag_pct_d[c];
                        sig_cnt_q[c] <= '0;
                        mag_cnt_q[c] <= '0;
                    end
                end else begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        sig_cnt_q[c] <= sig_sum[c];
                        mag_cnt_q[c] <= mag_sum[c];
                    end
                end
            end
        end
    end

    always_comb begin
        sig_pct = '0;
        mag_pct = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sig_pct[c*7 +: 7] = sig_pct_q[c];
            mag_pct[c*7 +: 7] = mag_pct_q[c];
        end
    end
    assign stat_stb = stb_q;
`else
    logic unused_mag_thr;
    assign unused_mag_thr = ^mag_thr;
    assign sig_pct  = '0;
    assign mag_pct  = '0;
    assign stat_stb = 1'b0;
`endif

endmodule

// File: tb/tb_mean_compens_mc.sv
module tb_mean_compens_mc;
    localparam int CH = 4;
    localparam int W  = 14;
    localparam int S  = 12;

    logic            clk = 1'b0;
    logic            reset_s, tau_load_s, in_valid_s;
    logic [3:0]      tau_s;
    logic [CH*W-1:0] data_in_s, data_out;
    logic [W-2:0]    mag_thr_s;
    logic            out_valid, stat_stb;
    logic [CH*7-1:0] sig_pct, mag_pct;

    always #5 clk = ~clk;

    mean_compens_mc dut (
        .clk(clk), .reset(reset_s), .tau(tau_s), .tau_load(tau_load_s),
        .in_valid(in_valid_s), .data_in(data_in_s), .data_out(data_out),
        .out_valid(out_valid), .mag_thr(mag_thr_s), .sig_pct(sig_pct),
        .mag_pct(mag_pct), .stat_stb(stat_stb)
    );

    int checks = 0;
    int errors = 0;
    int phase_bad = 0;
    int din [CH];
    int thr = 500;

    // Behavioural reference: plain integer arithmetic on the documented rules.
    int     m_tau;
    longint m_acc [CH];
    int     m_cnt;
    bit     m_ov;
    int     m_dout [CH];
    int     m_win;
    int     m_sig [CH], m_mag [CH], m_sigp [CH], m_magp [CH];
    bit     m_stb;

    typedef struct { int tau; int din; int exp_first; int exp_warm; } vec_t;
    vec_t tbl [7];

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int dout(int c);
        logic signed [W-1:0] v;
        v = data_out[c*W +: W];
        return int'(v);
    endfunction

    function automatic int spct(int c);
        logic [6:0] v;
        v = sig_pct[c*7 +: 7];
        return int'(v);
    endfunction

    function automatic int mpct(int c);
        logic [6:0] v;
        v = mag_pct[c*7 +: 7];
        return int'(v);
    endfunction

    task automatic model_update(bit r, bit l, int t, bit v);
        int tgt, d, a;
        if (r) begin
            m_tau = 4; m_cnt = 0; m_ov = 0; m_win = 0; m_stb = 0;
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0; m_dout[c] = 0; m_sig[c] = 0; m_mag[c] = 0;
                m_sigp[c] = 0; m_magp[c] = 0;
            end
            return;
        end
        // statistics use the output as it was before this edge
        m_stb = 0;
        if (l) begin
            m_win = 0;
            for (int c = 0; c < CH; c++) begin m_sig[c] = 0; m_mag[c] = 0; end
        end else if (m_ov) begin
            for (int c = 0; c < CH; c++) begin
                if (m_dout[c] >= 0) m_sig[c]++;
                a = (m_dout[c] < 0) ? -m_dout[c] : m_dout[c];
                if (a >= thr) m_mag[c]++;
            end
            m_win++;
            if (m_win == (1 << S)) begin
                for (int c = 0; c < CH; c++) begin
                    m_sigp[c] = m_sig[c] * 100 / (1 << S);
                    m_magp[c] = m_mag[c] * 100 / (1 << S);
                    m_sig[c] = 0; m_mag[c] = 0;
                end
                m_stb = 1; m_win = 0;
            end
        end
        if (l) begin
            m_tau = (t == 0) ? 1 : ((t > 15) ? 15 : t);
            m_cnt = 0; m_ov = 0;
            for (int c = 0; c < CH; c++) m_acc[c] = 0;
        end else if (v) begin
            tgt = 1 << (m_tau + 2);
            for (int c = 0; c < CH; c++) begin
                d = din[c] - int'(m_acc[c] >>> m_tau);
                m_dout[c] = (d > 8191) ? 8191 : ((d < -8192) ? -8192 : d);
                m_acc[c] += d;
            end
            if (m_cnt < tgt) m_cnt++;
            m_ov = (m_cnt >= tgt);
        end else begin
            m_ov = 0;
        end
    endtask

    task automatic step(bit r, bit l, int t, bit v);
        bit bad;
        reset_s = r; tau_load_s = l; tau_s = 4'(t); in_valid_s = v;
        for (int c = 0; c < CH; c++) data_in_s[c*W +: W] = din[c][W-1:0];
        mag_thr_s = thr[W-2:0];
        @(posedge clk);
        model_update(r, l, t, v);
        #1;
        bad = 0;
        if (out_valid !== m_ov) bad = 1;
        for (int c = 0; c < CH; c++) if (dout(c) != m_dout[c]) bad = 1;
`ifdef MEAN_COMPENS_STAT_EN
        if (stat_stb !== m_stb) bad = 1;
        for (int c = 0; c < CH; c++)
            if (spct(c) != m_sigp[c] || mpct(c) != m_magp[c]) bad = 1;
`else
        if (stat_stb !== 1'b0 || sig_pct !== '0 || mag_pct !== '0) bad = 1;
`endif
        if (bad) phase_bad++;
    endtask

    task automatic end_phase(string n);
        chk({"model_", n}, phase_bad, 0);
        phase_bad = 0;
    endtask

    task automatic set_all(int v);
        for (int c = 0; c < CH; c++) din[c] = v;
    endtask

    initial begin
        int k, prev, mono_bad, stb_at, sp, mp, a0, a1;
        bit seen;
        tbl[0] = '{0, 100, 100, 8};
        tbl[1] = '{1, -50, -50, 8};
        tbl[2] = '{2, 8191, 8191, 16};
        tbl[3] = '{3, -8192, -8192, 32};
        tbl[4] = '{4, 100, 100, 64};
        tbl[5] = '{6, -300, -300, 256};
        tbl[6] = '{7, 1234, 1234, 512};

        set_all(0);
        reset_s = 1; tau_load_s = 0; in_valid_s = 0; tau_s = 0;
        data_in_s = '0; mag_thr_s = '0;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out_zero", data_out == '0, 1);
        chk("rst_sig_pct", sig_pct, 0);
        chk("rst_mag_pct", mag_pct, 0);
        chk("rst_stat_stb", stat_stb, 0);
        end_phase("reset");

        // clamp, first output and warm-up length per time constant
        for (int i = 0; i < 7; i++) begin
            set_all(tbl[i].din);
            step(0, 1, tbl[i].tau, 0);
            chk("load_out_valid", out_valid, 0);
            k = 0; seen = 0;
            while (!seen && k < 2000) begin
                step(0, 0, 0, 1);
                k++;
                if (k == 1) chk($sformatf("first_out_tau%0d", tbl[i].tau), dout(0), tbl[i].exp_first);
                if (out_valid) seen = 1;
            end
            chk($sformatf("warm_len_tau%0d", tbl[i].tau), k, tbl[i].exp_warm);
        end
        end_phase("table");

        // constant 100 at tau=4 decays monotonically to |d|<=1 within 250 samples
        set_all(100);
        step(0, 1, 4, 0);
        prev = 1 << 20; mono_bad = 0;
        for (int n = 1; n <= 250; n++) begin
            step(0, 0, 0, 1);
            if (n == 1) chk("t1_first", dout(0), 100);
            if (dout(0) > prev) mono_bad++;
            prev = dout(0);
        end
        chk("t1_monotonic", mono_bad, 0);
        chk("t1_settled", (dout(0) <= 1 && dout(0) >= -1), 1);

        // in_valid gap during a transient: outputs drop, state holds
        set_all(500);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < CH; c++) din[c] = int'($urandom_range(0, 16383)) - 8192;
            step(0, 0, 0, 0);
            chk("gap_out_valid", out_valid, 0);
        end
        set_all(500);
        step(0, 0, 0, 1);
        chk("gap_resume_valid", out_valid, 1);
        end_phase("decay_gap");

        // occupancy statistics on alternating +/-1000
        thr = 500;
        step(0, 1, 4, 0);
        stb_at = -1; sp = -1; mp = -1;
        for (int n = 1; n <= 4200; n++) begin
            set_all((n % 2) ? 1000 : -1000);
            step(0, 0, 0, 1);
            if (stat_stb && stb_at < 0) begin
                stb_at = n; sp = spct(0); mp = mpct(3);
            end
        end
`ifdef MEAN_COMPENS_STAT_EN
        chk("stat_first_stb", stb_at, 64 + 4096);
        chk("stat_sig_pct", sp, 50);
        chk("stat_mag_pct", mp, 100);
`else
        chk("stat_stb_absent", stb_at, -1);
`endif
        end_phase("stats");

        // saturation after a long full-scale positive run
        step(0, 1, 8, 0);
        set_all(8191);
        for (int n = 0; n < 20000; n++) step(0, 0, 0, 1);
        set_all(-8192);
        step(0, 0, 0, 1);
        chk("t3_saturated", dout(0), -8192);
        end_phase("saturation");

        // reset mid-stream restores tau=4 and restarts warm-up
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < CH; c++) din[c] = int'($urandom_range(0, 2000)) - 1000;
            step(0, 0, 0, 1);
        end
        step(1, 0, 0, 1);
        chk("mid_rst_data_out", data_out == '0, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_pct", (sig_pct == '0) && (mag_pct == '0), 1);
        set_all(42);
        k = 0; seen = 0;
        while (!seen && k < 2000) begin
            step(0, 0, 0, 1);
            k++;
            if (out_valid) seen = 1;
        end
        chk("mid_rst_warm_len", k, 64);
        end_phase("midreset");

        // load with in_valid in the same cycle, independent channel offsets
        din[0] = 100; din[1] = -300; din[2] = 7777; din[3] = -5000;
        step(0, 1, 4, 1);
        chk("load_drop_valid", out_valid, 0);
        step(0, 0, 0, 1);
        chk("load_drop_ch0", dout(0), 100);
        chk("load_drop_ch1", dout(1), -300);
        for (int n = 0; n < 400; n++) begin
            din[0] = 100 + int'($urandom_range(0, 40)) - 20;
            din[1] = -300 + int'($urandom_range(0, 40)) - 20;
            din[2] = int'($urandom_range(0, 16383)) - 8192;
            din[3] = int'($urandom_range(0, 16383)) - 8192;
            thr = int'($urandom_range(0, 8191));
            if ($urandom_range(0, 99) == 0)
                step(0, 1, int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            else
                step(0, 0, 0, $urandom_range(0, 4) != 0);
        end
        step(0, 1, 4, 0);
        din[0] = 100; din[1] = -300;
        for (int n = 0; n < 250; n++) begin
            din[2] = int'($urandom_range(0, 16383)) - 8192;
            din[3] = int'($urandom_range(0, 16383)) - 8192;
            step(0, 0, 0, 1);
        end
        a0 = dout(0); a1 = dout(1);
        chk("conv_ch0", (a0 <= 1 && a0 >= -1), 1);
        chk("conv_ch1", (a1 <= 1 && a1 >= -1), 1);
        end_phase("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
